// File: rtl/clock_period_meter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clock_period_meter_pkg                                          |
// | Purpose  : Shared definitions for the period meter: FSM state encoding     |
// |            and default parameter values for counter width and sync depth.  |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package clock_period_meter_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meter_state_t;

endpackage : clock_period_meter_pkg
`default_nettype wire

// File: rtl/clock_period_meter_sync_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_edge_detect                                                |
// | Purpose  : Multi-flop synchronizer for an asynchronous input followed by   |
// |            a history flop; produces a single-cycle rising-edge pulse.      |
// | Ports    : i_clk   - sampling clock                                        |
// |            i_rst   - asynchronous active-high reset                        |
// |            i_async - asynchronous input                                    |
// |            o_rise  - one-cycle pulse on a synchronized 0->1 transition     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_level;

  // r_sync[0] is the metastability-catching flop; the last stage is the
  // first one safe to use as a level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= w_level;
    end
  end

  assign w_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = w_level & ~r_prev;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/clock_period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : clock_period_meter                                              |
// | Purpose  : Measures the rising-edge-to-rising-edge period of a slow        |
// |            asynchronous square wave in i_clk cycles and presents each      |
// |            result on a valid/ready output with drop indication.            |
// | Ports    : i_clk      - sole clock                                         |
// |            i_rst      - asynchronous active-high reset                     |
// |            i_sig      - asynchronous signal under measurement              |
// |            i_enable   - 1 measure, 0 abort and ignore edges                |
// |            o_period   - last captured period (saturating)                  |
// |            o_overflow - captured period saturated                          |
// |            o_valid    - unconsumed result held                             |
// |            i_ready    - consumer accept                                    |
// |            o_dropped  - one-cycle pulse when a result was discarded        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sig,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_period,
  output logic             o_overflow,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_dropped
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  meter_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_overflow;
  logic             r_valid;
  logic             r_dropped;
  logic             w_rise;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_sig),
    .o_rise  (w_rise)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_period   <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_dropped <= 1'b0;

      // Accept frees the output register; a capture later in this block
      // may immediately refill it, giving back-to-back results with no gap.
      if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end

      if (!i_enable) begin
        // Disable wins over an edge in the same cycle; held result untouched.
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // First edge only arms the counter; there is no reference edge yet.
            if (w_rise) begin
              r_cnt   <= c_cnt_one;
              r_state <= ST_MEASURE;
            end else begin
              r_cnt <= '0;
            end
          end

          ST_MEASURE: begin
            if (w_rise) begin
              r_cnt <= c_cnt_one;
              if (!r_valid || i_ready) begin
                r_period   <= r_cnt;
                r_overflow <= (r_cnt == c_cnt_max);
                r_valid    <= 1'b1;
              end else begin
                r_dropped <= 1'b1;
              end
            end else if (r_cnt != c_cnt_max) begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_period   = r_period;
  assign o_overflow = r_overflow;
  assign o_valid    = r_valid;
  assign o_dropped  = r_dropped;

endmodule : clock_period_meter
`default_nettype wire

// File: tb/tb_clock_period_meter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_clock_period_meter                                           |
// | Purpose  : Scoreboard bench for clock_period_meter (CNT_W=4 so that        |
// |            saturation is reachable with short waveforms).                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_clock_period_meter;

  localparam int CNT_W = 4;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig;
  logic             en;
  logic             rdy;
  logic [CNT_W-1:0] o_period;
  logic             o_overflow;
  logic             o_valid;
  logic             o_dropped;

  clock_period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sig      (sig),
    .i_enable   (en),
    .o_period   (o_period),
    .o_overflow (o_overflow),
    .o_valid    (o_valid),
    .i_ready    (rdy),
    .o_dropped  (o_dropped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   obs_drops = 0;
  int   exp_drops = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int p, input logic o);
    exp_t v;
    v.period = p[CNT_W-1:0];
    v.ovf    = o;
    exp_q.push_back(v);
  endtask

  // Inputs change 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      sig = 1'b0;
    end
  endtask

  // n rising edges spaced p cycles apart, high for p/2 cycles each.
  task automatic wave(input int p, input int n);
    repeat (n) begin
      for (int i = 0; i < p; i++) begin
        tick();
        sig = (i < p / 2);
      end
    end
  endtask

  // Abort any measurement so the next segment starts from a fresh re-arm.
  task automatic seg_start();
    tick();
    en  = 1'b0;
    sig = 1'b0;
    idle(4);
    en  = 1'b1;
  endtask

  // Monitor: samples one time unit before each rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        if (o_dropped) obs_drops++;
        if (o_valid && rdy) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got period %0d ovf %0d, expected none (t=%0t)",
                     o_period, o_overflow, $time);
          end else begin
            e = exp_q.pop_front();
            check("period", int'(o_period), int'(e.period));
            check("overflow", int'(o_overflow), int'(e.ovf));
          end
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    sig = 1'b0;
    en  = 1'b0;
    rdy = 1'b1;
    repeat (3) tick();
    check("reset_valid", int'(o_valid), 0);
    check("reset_period", int'(o_period), 0);
    check("reset_overflow", int'(o_overflow), 0);
    check("reset_dropped", int'(o_dropped), 0);
    rst = 1'b0;

    // Steady period 8: first edge re-arms, three results of 8.
    seg_start();
    push(8, 1'b0); push(8, 1'b0); push(8, 1'b0);
    wave(8, 4);

    // Period 20 saturates a 4-bit counter, then period 6 clears overflow.
    seg_start();
    push(15, 1'b1); push(15, 1'b1); push(15, 1'b1);
    push(6, 1'b0);  push(6, 1'b0);
    wave(20, 3);
    wave(6, 3);

    // Disable mid-period: the next edge re-arms instead of reporting 13.
    seg_start();
    push(10, 1'b0);
    wave(10, 2);
    tick();
    en  = 1'b0;
    sig = 1'b0;
    idle(2);
    en = 1'b1;
    push(10, 1'b0); push(10, 1'b0);
    wave(10, 3);

    // Back-pressure: first result 5 held, results 5 and 7 dropped.
    seg_start();
    rdy = 1'b0;
    push(5, 1'b0);
    exp_drops += 2;
    wave(5, 2);
    wave(7, 2);
    idle(6);
    rdy = 1'b1;
    idle(4);
    push(15, 1'b1);
    push(6, 1'b0);
    wave(6, 2);

    // Accept and capture in the same cycle: 4 leaves, 6 loads, no drop.
    seg_start();
    rdy = 1'b0;
    push(4, 1'b0);
    wave(4, 2);
    idle(2);
    tick(); sig = 1'b1;
    tick(); sig = 1'b1;
    tick(); sig = 1'b0; rdy = 1'b1;
    push(6, 1'b0);
    idle(3);

    // Asynchronous reset with a held result and a measurement in flight.
    seg_start();
    rdy = 1'b0;
    wave(4, 2);
    tick(); sig = 1'b1;
    tick(); sig = 1'b1;
    @(negedge clk);
    #3;
    rst = 1'b1;
    sig = 1'b0;
    #1;
    check("async_rst_valid", int'(o_valid), 0);
    check("async_rst_period", int'(o_period), 0);
    check("async_rst_overflow", int'(o_overflow), 0);
    check("async_rst_dropped", int'(o_dropped), 0);
    tick();
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    push(8, 1'b0); push(8, 1'b0);
    wave(8, 3);
    idle(6);

    check("dropped_count", obs_drops, exp_drops);
    check("pending_results", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_clock_period_meter
`default_nettype wire
